// File: rtl/sobel_batch_sequencer.sv
// Frame sequencer for the SobelFilter p2p datapath: feeds source pixels in row batches,
// joins the r/g/b result channels into one 24-bit stream and holds each batch until it drains.
module sobel_batch_sequencer #(
  parameter int IMG_W          = 512,
  parameter int IMG_H          = 512,
  parameter int ROWS_PER_BATCH = 4,
  localparam int NUM_BATCHES   = (IMG_H + ROWS_PER_BATCH - 1) / ROWS_PER_BATCH,
  localparam int BIDX_W        = (NUM_BATCHES > 1) ? $clog2(NUM_BATCHES) : 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  input  logic              src_vld,
  output logic              src_busy,
  input  logic [23:0]       src_data,
  output logic              flt_rgb_vld,
  input  logic              flt_rgb_busy,
  output logic [23:0]       flt_rgb_data,
  input  logic              flt_r_vld,
  input  logic              flt_g_vld,
  input  logic              flt_b_vld,
  output logic              flt_r_busy,
  output logic              flt_g_busy,
  output logic              flt_b_busy,
  input  logic [7:0]        flt_r_data,
  input  logic [7:0]        flt_g_data,
  input  logic [7:0]        flt_b_data,
  output logic              out_vld,
  input  logic              out_busy,
  output logic [23:0]       out_data,
  output logic [BIDX_W-1:0] batch_idx
);

  localparam int CNT_W     = $clog2(IMG_W * ROWS_PER_BATCH + 1);
  localparam int LAST_ROWS = IMG_H - (NUM_BATCHES - 1) * ROWS_PER_BATCH;
  localparam logic [CNT_W-1:0]  FULL_BSIZE = CNT_W'(IMG_W * ROWS_PER_BATCH);
  localparam logic [CNT_W-1:0]  LAST_BSIZE = CNT_W'(IMG_W * LAST_ROWS);
  localparam logic [BIDX_W-1:0] LAST_IDX   = BIDX_W'(NUM_BATCHES - 1);

  typedef enum logic [1:0] {IDLE, FEED, WAIT, DONE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] in_cnt, out_cnt, in_cnt_nxt, out_cnt_nxt, bsize;
  logic             feed_en, collect, in_xfer, fire, last_batch, batch_adv;

  logic [2:0]       full, ch_vld, ch_busy, load;
  logic [2:0][7:0]  ch_data, hold;

  // Only the final batch can be short; every other batch is a full ROWS_PER_BATCH rows.
  assign last_batch = (batch_idx == LAST_IDX);
  assign bsize      = last_batch ? LAST_BSIZE : FULL_BSIZE;

  assign feed_en      = (state == FEED);
  assign collect      = (state == FEED) || (state == WAIT);
  assign flt_rgb_vld  = src_vld & feed_en;
  assign src_busy     = flt_rgb_busy | ~feed_en;
  assign flt_rgb_data = src_data;
  assign in_xfer      = flt_rgb_vld & ~flt_rgb_busy;

  assign ch_vld  = {flt_b_vld, flt_g_vld, flt_r_vld};
  assign ch_data = {flt_b_data, flt_g_data, flt_r_data};
  assign out_vld = &full;
  assign fire    = out_vld & ~out_busy;
  // A held byte frees its slot on the fire cycle itself, so the next byte can load at once.
  assign ch_busy = (full & {3{~fire}}) | {3{~collect}};
  assign load    = ch_vld & ~ch_busy;
  assign {flt_b_busy, flt_g_busy, flt_r_busy} = ch_busy;
  assign out_data = hold;

  assign in_cnt_nxt  = in_cnt + CNT_W'(in_xfer);
  assign out_cnt_nxt = out_cnt + CNT_W'(fire);
  assign busy        = (state != IDLE);
  assign done        = (state == DONE);

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    state_nxt = state;
    batch_adv = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = FEED;
      FEED: if (in_xfer && (in_cnt_nxt == bsize)) state_nxt = WAIT;
      WAIT: if (out_cnt_nxt == bsize) begin
        if (last_batch) begin
          state_nxt = DONE;
        end else begin
          state_nxt = FEED;
          batch_adv = 1'b1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: state is assigned with non-blocking <= so every register samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state     <= IDLE;
      in_cnt    <= '0;
      out_cnt   <= '0;
      batch_idx <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE) begin
        in_cnt    <= '0;
        out_cnt   <= '0;
        batch_idx <= '0;
      end else if (batch_adv) begin
        in_cnt    <= '0;
        out_cnt   <= '0;
        batch_idx <= batch_idx + BIDX_W'(1);
      end else begin
        in_cnt  <= in_cnt_nxt;
        out_cnt <= out_cnt_nxt;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) full <= '0;
    else        full <= (full & {3{~fire}}) | load;
  end

  // NOTE: the byte registers are deliberately not reset; the full flags qualify them,
  // so their power-up contents are never observed.
  always_ff @(posedge i_clk) begin
    for (int c = 0; c < 3; c++) begin
      if (load[c]) hold[c] <= ch_data[c];
    end
  end

endmodule

// File: tb/tb_sobel_batch_sequencer.sv
// Self-checking bench for sobel_batch_sequencer: reset/idle vector table, directed frames
// and randomized frames checked against a transaction-level model of the batch protocol.
module tb_sobel_batch_sequencer;

  localparam int IMG_W = 4;
  localparam int IMG_H = 6;
  localparam int RPB   = 4;
  localparam int NB    = (IMG_H + RPB - 1) / RPB;
  localparam int FRAME_PIX = IMG_W * IMG_H;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic        start, busy, done;
  logic        src_vld, src_busy;
  logic [23:0] src_data;
  logic        flt_rgb_vld, flt_rgb_busy;
  logic [23:0] flt_rgb_data;
  logic        flt_r_vld, flt_g_vld, flt_b_vld;
  logic        flt_r_busy, flt_g_busy, flt_b_busy;
  logic [7:0]  flt_r_data, flt_g_data, flt_b_data;
  logic        out_vld, out_busy;
  logic [23:0] out_data;
  logic [0:0]  batch_idx;

  always #5 i_clk = ~i_clk;

  sobel_batch_sequencer #(.IMG_W(IMG_W), .IMG_H(IMG_H), .ROWS_PER_BATCH(RPB)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .start(start), .busy(busy), .done(done),
    .src_vld(src_vld), .src_busy(src_busy), .src_data(src_data),
    .flt_rgb_vld(flt_rgb_vld), .flt_rgb_busy(flt_rgb_busy), .flt_rgb_data(flt_rgb_data),
    .flt_r_vld(flt_r_vld), .flt_g_vld(flt_g_vld), .flt_b_vld(flt_b_vld),
    .flt_r_busy(flt_r_busy), .flt_g_busy(flt_g_busy), .flt_b_busy(flt_b_busy),
    .flt_r_data(flt_r_data), .flt_g_data(flt_g_data), .flt_b_data(flt_b_data),
    .out_vld(out_vld), .out_busy(out_busy), .out_data(out_data), .batch_idx(batch_idx)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Filter stand-in: each channel returns a distinct tag of its input byte after a latency.
  typedef struct { logic [7:0] v; int rdy; } res_t;
  res_t        rq[$], gq[$], bq[$];
  logic [23:0] exp_q[$];

  function automatic logic [23:0] filt(input logic [23:0] p);
    return {~p[23:16], p[15:8] + 8'd1, p[7:0] ^ 8'h3C};
  endfunction

  function automatic int bsize_of(input int b);
    int rows;
    rows = IMG_H - b * RPB;
    return IMG_W * ((rows < RPB) ? rows : RPB);
  endfunction

  // Transaction-level view of the frame: pixels accepted / results fired per batch.
  bit       m_active, m_done_ph;
  int       m_batch, m_in, m_out;
  bit [2:0] m_held;

  task automatic model_reset();
    m_active = 0; m_done_ph = 0; m_batch = 0; m_in = 0; m_out = 0; m_held = '0;
    rq.delete(); gq.delete(); bq.delete(); exp_q.delete();
  endtask

  task automatic drive_idle();
    start = 0; src_vld = 0; src_data = '0; flt_rgb_busy = 0;
    flt_r_vld = 0; flt_g_vld = 0; flt_b_vld = 0;
    flt_r_data = '0; flt_g_data = '0; flt_b_data = '0; out_busy = 0;
  endtask

  task automatic run_frame(input int lat_r, input int lat_g, input int lat_b, input int jitter,
                           input int src_pct, input int fbusy_pct, input int obusy_pct,
                           input int ob_from, input int ob_len, input int src_limit,
                           input int abort_out, input bit mid_start);
    int k, bs, fires, sent, done_cnt, in_b0;
    bit src_pend, finished, aborted, loadable, feed, e_ovld, e_fire;
    bit in_x, fire, r_x, g_x, b_x, b0;
    logic [23:0] src_px, p;
    fires = 0; sent = 0; done_cnt = 0; in_b0 = 0;
    src_pend = 0; finished = 0; aborted = 0; src_px = '0;
    for (k = 0; k < 3000 && !finished; k++) begin
      @(negedge i_clk);
      start = (k == 0) || (mid_start && k == 20);
      if (!src_pend && sent < src_limit && $urandom_range(99) < src_pct) begin
        src_pend = 1;
        src_px   = 24'($urandom);
      end
      src_vld      = src_pend;
      src_data     = src_px;
      flt_rgb_busy = ($urandom_range(99) < fbusy_pct);
      flt_r_vld    = (rq.size() > 0) && (rq[0].rdy <= cyc);
      flt_g_vld    = (gq.size() > 0) && (gq[0].rdy <= cyc);
      flt_b_vld    = (bq.size() > 0) && (bq[0].rdy <= cyc);
      flt_r_data   = (rq.size() > 0) ? rq[0].v : 8'h00;
      flt_g_data   = (gq.size() > 0) ? gq[0].v : 8'h00;
      flt_b_data   = (bq.size() > 0) ? bq[0].v : 8'h00;
      out_busy     = (k >= ob_from && k < ob_from + ob_len) ||
                     (abort_out > 0 && fires >= abort_out) ||
                     ($urandom_range(99) < obusy_pct);
      #1;
      bs       = bsize_of(m_batch);
      loadable = m_active && !m_done_ph;
      feed     = loadable && (m_in < bs);
      e_ovld   = &m_held;
      e_fire   = e_ovld && !out_busy;
      check("busy", busy, m_active);
      check("done", done, m_done_ph);
      check("batch_idx", batch_idx, m_batch);
      check("flt_rgb_vld", flt_rgb_vld, src_vld && feed);
      check("src_busy", src_busy, flt_rgb_busy || !feed);
      check("flt_rgb_data", flt_rgb_data, src_data);
      check("out_vld", out_vld, e_ovld);
      check("flt_r_busy", flt_r_busy, !loadable || (m_held[0] && !e_fire));
      check("flt_g_busy", flt_g_busy, !loadable || (m_held[1] && !e_fire));
      check("flt_b_busy", flt_b_busy, !loadable || (m_held[2] && !e_fire));
      if (done) done_cnt++;
      in_x = flt_rgb_vld && !flt_rgb_busy;
      fire = out_vld && !out_busy;
      r_x  = flt_r_vld && !flt_r_busy;
      g_x  = flt_g_vld && !flt_g_busy;
      b_x  = flt_b_vld && !flt_b_busy;
      b0   = (batch_idx == 1'b0);
      if (fire) begin
        if (exp_q.size() == 0) check("out_extra", 1, 0);
        else                   check("out_data", out_data, exp_q.pop_front());
        fires++;
      end
      @(posedge i_clk);
      cyc++;
      if (in_x) begin
        sent++;
        src_pend = 0;
        if (b0) in_b0++;
        p = filt(src_px);
        exp_q.push_back(p);
        rq.push_back('{v: p[7:0],   rdy: cyc + lat_r + int'($urandom_range(jitter))});
        gq.push_back('{v: p[15:8],  rdy: cyc + lat_g + int'($urandom_range(jitter))});
        bq.push_back('{v: p[23:16], rdy: cyc + lat_b + int'($urandom_range(jitter))});
      end
      if (r_x) void'(rq.pop_front());
      if (g_x) void'(gq.pop_front());
      if (b_x) void'(bq.pop_front());
      if (!m_active) begin
        if (start) begin
          m_active = 1; m_batch = 0; m_in = 0; m_out = 0;
        end
      end else if (m_done_ph) begin
        m_active = 0; m_done_ph = 0; finished = 1;
      end else begin
        m_held = (m_held & ~{3{fire}}) | {b_x, g_x, r_x};
        m_in  += int'(in_x);
        m_out += int'(fire);
        if (m_in == bs && m_out == bs) begin
          if (m_batch == NB - 1) m_done_ph = 1;
          else begin
            m_batch++; m_in = 0; m_out = 0;
          end
        end
      end
      if (abort_out > 0 && sent >= src_limit && fires >= abort_out) begin
        aborted = 1; finished = 1;
      end
    end
    if (!finished) check("frame_timeout", 1, 0);
    if (aborted) begin
      check("abort_no_done", done_cnt, 0);
      @(negedge i_clk);
      #2 i_rst = 0;
      #1;
      model_reset();
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_src_busy", src_busy, 1);
      check("rst_flt_rgb_vld", flt_rgb_vld, 0);
      check("rst_out_vld", out_vld, 0);
      check("rst_res_busy", {flt_b_busy, flt_g_busy, flt_r_busy}, 3'b111);
      check("rst_batch_idx", batch_idx, 0);
      drive_idle();
      repeat (2) @(negedge i_clk);
      i_rst = 1;
    end else begin
      check("frame_results", fires, FRAME_PIX);
      check("frame_done_pulses", done_cnt, 1);
      check("batch0_inputs", in_b0, bsize_of(0));
      check("frame_leftover", exp_q.size(), 0);
    end
  endtask

  typedef struct {
    logic        rst_n, start, src_vld;
    logic [23:0] src_data;
    logic        flt_rgb_busy;
    logic [2:0]  res_vld;
    logic        out_busy;
    logic        e_src_busy, e_flt_rgb_vld;
    logic [2:0]  e_res_busy;
    logic        e_out_vld, e_busy, e_done;
  } vec_t;

  vec_t vecs[6];

  initial begin
    // Reset entries, then idle entries with results arriving while no frame runs.
    vecs[0] = '{1'b0, 1'b1, 1'b1, 24'hA1B2C3, 1'b0, 3'b111, 1'b0, 1'b1, 1'b0, 3'b111, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 24'h000000, 1'b1, 3'b101, 1'b1, 1'b1, 1'b0, 3'b111, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 24'hFFFFFF, 1'b0, 3'b010, 1'b0, 1'b1, 1'b0, 3'b111, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 24'h5A5AA5, 1'b0, 3'b111, 1'b0, 1'b1, 1'b0, 3'b111, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 1'b1, 24'h13579B, 1'b1, 3'b100, 1'b1, 1'b1, 1'b0, 3'b111, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 24'h2468AC, 1'b0, 3'b011, 1'b0, 1'b1, 1'b0, 3'b111, 1'b0, 1'b0, 1'b0};

    drive_idle();
    i_rst = 0;
    model_reset();
    for (int i = 0; i < 6; i++) begin
      @(negedge i_clk);
      i_rst        = vecs[i].rst_n;
      start        = vecs[i].start;
      src_vld      = vecs[i].src_vld;
      src_data     = vecs[i].src_data;
      flt_rgb_busy = vecs[i].flt_rgb_busy;
      {flt_b_vld, flt_g_vld, flt_r_vld} = vecs[i].res_vld;
      flt_r_data   = 8'($urandom);
      flt_g_data   = 8'($urandom);
      flt_b_data   = 8'($urandom);
      out_busy     = vecs[i].out_busy;
      #1;
      check("vec_src_busy", src_busy, vecs[i].e_src_busy);
      check("vec_flt_rgb_vld", flt_rgb_vld, vecs[i].e_flt_rgb_vld);
      check("vec_flt_rgb_data", flt_rgb_data, vecs[i].src_data);
      check("vec_res_busy", {flt_b_busy, flt_g_busy, flt_r_busy}, vecs[i].e_res_busy);
      check("vec_out_vld", out_vld, vecs[i].e_out_vld);
      check("vec_busy", busy, vecs[i].e_busy);
      check("vec_done", done, vecs[i].e_done);
      check("vec_batch_idx", batch_idx, 0);
    end
    drive_idle();

    // Continuous source, 3-cycle filter, no stalls.
    run_frame(3, 3, 3, 0, 100, 0, 0, 0, 0, FRAME_PIX, 0, 1'b0);
    // r returns 5 cycles ahead of g/b; downstream stalls 4 cycles; start pulsed mid-frame.
    run_frame(1, 6, 6, 0, 100, 0, 0, 10, 4, FRAME_PIX, 0, 1'b1);
    // Abandon the frame after 10 inputs and 4 results, then run a clean frame.
    run_frame(3, 3, 3, 0, 100, 0, 0, 0, 0, 10, 4, 1'b0);
    run_frame(3, 3, 3, 0, 100, 0, 0, 0, 0, FRAME_PIX, 0, 1'b0);
    for (int f = 0; f < 5; f++) begin
      run_frame(int'($urandom_range(1, 4)), int'($urandom_range(1, 4)), int'($urandom_range(1, 4)),
                int'($urandom_range(3)), int'($urandom_range(30, 100)), int'($urandom_range(40)),
                int'($urandom_range(50)), 0, 0, FRAME_PIX, 0, f[0]);
    end

    @(negedge i_clk);
    #1;
    check("final_busy", busy, 0);
    check("final_src_busy", src_busy, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sobel_batch_sequencer.md
Name: sobel_batch_sequencer

Overview:
- Sequences one full frame through the SobelFilter p2p datapath in row batches of ROWS_PER_BATCH rows.
- Gates source pixels into the filter input channel and counts pixels in and results out per batch.
- Joins the three independent result channels (r/g/b) into one 24-bit output stream.
- Holds off the next batch until every result of the current batch has drained. Sits between the frame DMA/source and the SobelFilter instance.

Parameters:
IMG_W, 512, pixels per row
IMG_H, 512, rows per frame
ROWS_PER_BATCH, 4, rows per batch; last batch is partial if IMG_H is not a multiple

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  reset, asynchronous, active-low
start  in  1  one-cycle pulse; begins a frame when idle
busy  out  1  high whenever a frame is in progress (state != IDLE)
done  out  1  one-cycle pulse when the last result of the frame is accepted
src_vld  in  1  source pixel valid
src_busy  out  1  source stall
src_data  in  24  source pixel, r[7:0] g[15:8] b[23:16]
flt_rgb_vld  out  1  filter input valid
flt_rgb_busy  in  1  filter input stall
flt_rgb_data  out  24  filter input pixel, equal to src_data
flt_r_vld / flt_g_vld / flt_b_vld  in  1 each  filter result valid
flt_r_busy / flt_g_busy / flt_b_busy  out  1 each  filter result stall
flt_r_data / flt_g_data / flt_b_data  in  8 each  filter result bytes
out_vld  out  1  joined result valid
out_busy  in  1  downstream stall
out_data  out  24  {b,g,r}, same packing as src_data
batch_idx  out  clog2(ceil(IMG_H/ROWS_PER_BATCH))  current batch number

Behaviour:
- Handshake on every channel: a transfer occurs on a rising edge where vld=1 and busy=0. vld and data hold stable until transfer.
- Reset (i_rst=0, asynchronous): state=IDLE; all counters 0; hold registers empty.
  - Outputs during reset: busy=0, done=0, out_vld=0, flt_rgb_vld=0, src_busy=1, flt_*_busy=1, batch_idx=0.
  - Reset mid-frame abandons the frame. No done pulse is issued.
- States:
  - IDLE: start goes to FEED; batch_idx=0; counters cleared.
  - FEED: input gate is open. When in_cnt reaches bsize (counted on the transfer cycle), go to WAIT.
  - WAIT: input gate is closed. When out_cnt reaches bsize:
    - if this is the last batch, go to DONE;
    - otherwise go to FEED with batch_idx+1 and in_cnt=out_cnt=0.
  - DONE: done=1 for one cycle, then IDLE.
- start is ignored outside IDLE.
- bsize = IMG_W * min(ROWS_PER_BATCH, IMG_H - batch_idx*ROWS_PER_BATCH).
- Input gate (combinational pass-through, zero latency):
  - feed_en = (state==FEED).
  - flt_rgb_vld = src_vld & feed_en.
  - src_busy = flt_rgb_busy | ~feed_en.
  - flt_rgb_data = src_data.
  - in_cnt increments on each filter-input transfer.
- Result join:
  - One 8-bit hold register plus a full flag per channel.
  - A channel loads when its vld=1, its busy=0, and state is FEED or WAIT.
  - out_vld = full_r & full_g & full_b.
  - fire = out_vld & ~out_busy. On fire, all three full flags clear and out_cnt increments.
  - flt_x_busy = (full_x & ~fire) | state in {IDLE, DONE}. This lets a new byte load in the same cycle as fire.
  - Channels may arrive in any order or on any cycle. Results may arrive while still in FEED.
- Transition timing: the last fire of the last batch moves the state to DONE on that edge; done is asserted the following cycle.
- Counter widths: clog2(IMG_W*ROWS_PER_BATCH+1). Counters never exceed bsize, because input is gated at bsize.

Test Plan:
- Directed parameters for all scenarios: IMG_W=4, IMG_H=6, ROWS_PER_BATCH=4.
- Reset values: hold i_rst=0 with random inputs -> src_busy=1, all flt_*_busy=1, out_vld=0, busy=0, done=0.
- Full frame, no stalls: start, continuous src, filter returns results 3 cycles after input -> 16 inputs, src_busy=1 until 16 results are out, batch_idx becomes 1, then 8 inputs; 24 out_data words, each {b,g,r}; single done pulse; busy falls the cycle after done.
- Skewed channels: r arrives 5 cycles before g and b, with out_busy=1 for 4 cycles -> flt_r_busy=1 while r is held; out_data correct; no byte lost or duplicated; simultaneous reload on the fire cycle is accepted.
- Batch boundary hold: src_vld held high through the 16th pixel -> flt_rgb_vld=0 from the next cycle until the 16th result fires; in_cnt never exceeds 16.
- start while busy, plus results arriving in IDLE -> start ignored, no state change; flt_*_busy=1 in IDLE.
- Reset mid-batch (after 10 inputs and 4 results) -> immediate IDLE, no done pulse; a following start runs a clean frame of 24 results.
